spi_ad_seq_ctrl: RTL and testbench
==================================

Name: spi_ad_seq_ctrl

Overview:
- Sequencer and arbiter in front of the ADC serial-port engine.
- After Start, walks a register table (write/read entries) through the engine and verifies read-back entries.
- After initialisation, grants single host register accesses one at a time.
- Owns the engine's New_Word/Addr/Data/RW inputs. Observes its Over/q outputs through synchronisers.

Parameters:
- NUM_REGS, 16, number of table entries walked (1..255).
- PULSE_LEN, 4, CLK cycles New_Word is held high per transaction (≥2).
- TIMEOUT, 1023, CLK cycles allowed from New_Word fall to Over rise before error.

Ports:
- CLK  in  1  system clock.
- RST_n  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle pulse; begins table walk (ignored unless IDLE).
- Tbl_Idx  out  8  table entry index; table returns entry combinationally.
- Tbl_Entry  in  22  {RW, Addr[12:0], Data[7:0]}; RW 1 = read/verify, 0 = write.
- Host_Req  in  1  host access request, held until Host_Ack.
- Host_RW  in  1  1 read, 0 write.
- Host_Addr  in  13  host register address.
- Host_Data  in  8  host write data.
- Host_Ack  out  1  one-cycle pulse on host transaction completion.
- Host_Q  out  8  read data, valid with Host_Ack, held until next ack.
- New_Word  out  1  engine load pulse.
- Addr  out  13  engine address, stable from PULSE until FINISH.
- Data  out  8  engine write data, same stability.
- RW  out  1  engine direction, same stability.
- Over  in  1  engine done flag (engine clock domain).
- q  in  8  engine read data (quasi-static once Over=1).
- Busy  out  1  high in any state except IDLE and DONE.
- Init_Done  out  1  sticky; table walk finished without error.
- Error  out  1  sticky; verify mismatch or timeout.
- Err_Idx  out  8  table index of first error; 8'hFF for host timeout.

Behaviour:
- Reset values: New_Word=0, Addr=0, Data=0, RW=0, Host_Ack=0, Host_Q=0, Busy=0, Init_Done=0, Error=0, Err_Idx=0, Tbl_Idx=0, state IDLE, sync flops 0.
- Over passes a 2-flop synchroniser (ovs). q is sampled once in FINISH, 2 cycles after ovs rises, so it has settled.
- States:
  - IDLE: Start → LOAD with Tbl_Idx=0, src=TABLE. Host_Req is not granted.
  - LOAD: latch Tbl_Entry into Addr/Data/RW → PULSE. Takes 1 cycle.
  - PULSE: New_Word=1 for PULSE_LEN cycles → WAIT_CLR.
  - WAIT_CLR: wait ovs=0, which confirms the engine cleared Over. Timeout counter runs from New_Word fall.
  - WAIT_OVER: wait ovs=1 → FINISH. Counter reaching TIMEOUT in WAIT_CLR or WAIT_OVER → ERR.
  - FINISH, TABLE source:
    - If RW=1 and q≠Data → ERR.
    - Else if Tbl_Idx=NUM_REGS-1 → DONE with Init_Done=1.
    - Else Tbl_Idx+1 → LOAD.
  - FINISH, HOST source: Host_Q=q if RW=1 (else Host_Q unchanged), Host_Ack=1 for one cycle → DONE.
  - ERR: Error=1; Err_Idx=Tbl_Idx, or FF for host → IDLE. Init_Done stays 0.
  - DONE: Host_Req=1 → latch Host_* into Addr/Data/RW, src=HOST → PULSE.
- Start is ignored in every state except IDLE.
- Start in IDLE clears Error, Err_Idx and Init_Done. This is the re-init path after an error.
- Host_Req is ignored in IDLE and during any transaction; the host waits.
- Host_Req and Start in the same cycle in DONE: Host wins, because Start is ignored there.
- Host_Req still high in the cycle after Host_Ack is treated as a new request. The host must drop Req on Ack.
- Timeout counter: 10+ bits, saturating, cleared on entry to PULSE.
- Reset mid-transaction: all outputs return to reset values immediately. The engine is left with New_Word=0; the next Start restarts at index 0.
- NUM_REGS=1: a single transaction, then DONE.

Test Plan:
- Table of 3 writes then 1 read expecting 8'h5A, engine model returns 5A → 4 New_Word pulses of 4 cycles each, Tbl_Idx 0..3, Init_Done=1, Error=0, Busy falls.
- Same table, model returns 8'h5B on entry 3 → Error=1, Err_Idx=3, Init_Done=0, state IDLE. A new Start clears Error and reruns.
- Model never raises Over on entry 1 → Error=1, Err_Idx=1 exactly TIMEOUT+1 cycles after the New_Word fall ±1.
- After DONE, host read of addr 13'h0014 with model q=8'hC3 → Addr=0014, RW=1, Host_Ack one cycle, Host_Q=C3. Then host write → Host_Q unchanged.
- Host_Req asserted during table walk → no Host_Ack until Init_Done. Request served once in DONE; Start pulses in DONE produce no New_Word.
- RST_n low during WAIT_OVER → New_Word, Busy, Init_Done all 0 asynchronously. Start after release walks from Tbl_Idx=0.

Source files
------------

// File: rtl/spi_ad_seq_ctrl.sv
// rtl/spi_ad_seq_ctrl.sv - ADC serial-port sequencer: init table walk with read-back verify, then host access arbiter
module spi_ad_seq_ctrl #(
  parameter int NUM_REGS  = 16,
  parameter int PULSE_LEN = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        Start,
  output logic [7:0]  Tbl_Idx,
  input  logic [21:0] Tbl_Entry,
  input  logic        Host_Req,
  input  logic        Host_RW,
  input  logic [12:0] Host_Addr,
  input  logic [7:0]  Host_Data,
  output logic        Host_Ack,
  output logic [7:0]  Host_Q,
  output logic        New_Word,
  output logic [12:0] Addr,
  output logic [7:0]  Data,
  output logic        RW,
  input  logic        Over,
  input  logic [7:0]  q,
  output logic        Busy,
  output logic        Init_Done,
  output logic        Error,
  output logic [7:0]  Err_Idx
);

  localparam int TW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
  localparam logic [PW-1:0] P_LAST = PW'(PULSE_LEN - 1);
  localparam logic [7:0]    T_LAST = 8'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PULSE, S_WAIT_CLR, S_WAIT_OVER, S_FINISH, S_ERR, S_DONE
  } state_t;

  state_t        state;
  logic          ov_s1, ovs, src_host;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic          timed_out;

  assign timed_out = (tcnt >= T_MAX);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= S_IDLE;
      ov_s1     <= 1'b0;
      ovs       <= 1'b0;
      src_host  <= 1'b0;
      pcnt      <= '0;
      tcnt      <= '0;
      Tbl_Idx   <= 8'h00;
      Host_Ack  <= 1'b0;
      Host_Q    <= 8'h00;
      New_Word  <= 1'b0;
      Addr      <= 13'h0000;
      Data      <= 8'h00;
      RW        <= 1'b0;
      Busy      <= 1'b0;
      Init_Done <= 1'b0;
      Error     <= 1'b0;
      Err_Idx   <= 8'h00;
    end else begin
      Host_Ack <= 1'b0;
      ov_s1    <= Over;
      ovs      <= ov_s1;
      case (state)
        S_IDLE: begin
          if (Start) begin
            Tbl_Idx   <= 8'h00;
            src_host  <= 1'b0;
            Error     <= 1'b0;
            Err_Idx   <= 8'h00;
            Init_Done <= 1'b0;
            Busy      <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          RW       <= Tbl_Entry[21];
          Addr     <= Tbl_Entry[20:8];
          Data     <= Tbl_Entry[7:0];
          New_Word <= 1'b1;
          pcnt     <= '0;
          tcnt     <= '0;
          state    <= S_PULSE;
        end
        S_PULSE: begin
          if (pcnt == P_LAST) begin
            New_Word <= 1'b0;
            state    <= S_WAIT_CLR;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        // Error is raised on the timeout edge itself so it lands TIMEOUT+1 cycles after New_Word falls.
        S_WAIT_CLR, S_WAIT_OVER: begin
          if (timed_out) begin
            Error   <= 1'b1;
            Err_Idx <= src_host ? 8'hFF : Tbl_Idx;
            state   <= S_ERR;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (state == S_WAIT_CLR && !ovs)
              state <= S_WAIT_OVER;
            else if (state == S_WAIT_OVER && ovs)
              state <= S_FINISH;
          end
        end
        S_FINISH: begin
          if (src_host) begin
            if (RW) Host_Q <= q;
            Host_Ack <= 1'b1;
            Busy     <= 1'b0;
            state    <= S_DONE;
          end else if (RW && (q != Data)) begin
            Error   <= 1'b1;
            Err_Idx <= Tbl_Idx;
            state   <= S_ERR;
          end else if (Tbl_Idx == T_LAST) begin
            Init_Done <= 1'b1;
            Busy      <= 1'b0;
            state     <= S_DONE;
          end else begin
            Tbl_Idx <= Tbl_Idx + 1'b1;
            state   <= S_LOAD;
          end
        end
        S_ERR: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_DONE: begin
          if (Host_Req) begin
            Addr     <= Host_Addr;
            Data     <= Host_Data;
            RW       <= Host_RW;
            src_host <= 1'b1;
            New_Word <= 1'b1;
            pcnt     <= '0;
            tcnt     <= '0;
            Busy     <= 1'b1;
            state    <= S_PULSE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ad_seq_ctrl.sv
// tb/tb_spi_ad_seq_ctrl.sv - directed bench: table walk, verify error, timeout, host access, reset mid-transaction
module tb_spi_ad_seq_ctrl;
  localparam int NR = 4, PL = 4, TO = 60;

  logic        CLK = 1'b0, RST_n = 1'b0, Start = 1'b0;
  logic [7:0]  Tbl_Idx;
  logic [21:0] Tbl_Entry;
  logic        Host_Req = 1'b0, Host_RW = 1'b0;
  logic [12:0] Host_Addr = 13'h0;
  logic [7:0]  Host_Data = 8'h0;
  logic        Host_Ack, New_Word, RW, Over, Busy, Init_Done, Error;
  logic [7:0]  Host_Q, Data, q, Err_Idx;
  logic [12:0] Addr;
  int checks = 0, failures = 0;

  spi_ad_seq_ctrl #(.NUM_REGS(NR), .PULSE_LEN(PL), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_n(RST_n), .Start(Start), .Tbl_Idx(Tbl_Idx), .Tbl_Entry(Tbl_Entry),
    .Host_Req(Host_Req), .Host_RW(Host_RW), .Host_Addr(Host_Addr), .Host_Data(Host_Data),
    .Host_Ack(Host_Ack), .Host_Q(Host_Q), .New_Word(New_Word), .Addr(Addr), .Data(Data),
    .RW(RW), .Over(Over), .q(q), .Busy(Busy), .Init_Done(Init_Done), .Error(Error),
    .Err_Idx(Err_Idx));

  always #5 CLK = ~CLK;

  always_comb begin
    case (Tbl_Idx)
      8'd0:    Tbl_Entry = {1'b0, 13'h0001, 8'h11};
      8'd1:    Tbl_Entry = {1'b0, 13'h0002, 8'h22};
      8'd2:    Tbl_Entry = {1'b0, 13'h0003, 8'h33};
      8'd3:    Tbl_Entry = {1'b1, 13'h0004, 8'h5A};
      default: Tbl_Entry = 22'h0;
    endcase
  end

  // Engine model: clears Over on New_Word rise, raises it with q a few cycles later unless hung.
  logic [7:0] model_q = 8'h5A, hang_idx = 8'h0, q_r = 8'h0;
  logic       hang_en = 1'b0, nw_d = 1'b0, eact = 1'b0, ehang = 1'b0, over_r = 1'b1;
  int         ecnt = 0;
  assign Over = over_r;
  assign q    = q_r;
  always @(posedge CLK) begin
    nw_d <= New_Word;
    if (New_Word && !nw_d) begin
      over_r <= 1'b0;
      eact   <= 1'b1;
      ecnt   <= 5;
      ehang  <= hang_en && (Tbl_Idx == hang_idx);
    end else if (eact) begin
      if (ecnt == 0) begin
        eact <= 1'b0;
        if (!ehang) begin
          over_r <= 1'b1;
          q_r    <= model_q;
        end
      end else begin
        ecnt <= ecnt - 1;
      end
    end
  end

  int         nw_rises = 0, bad_len = 0, cur_len = 0;
  logic       nw_m = 1'b0;
  logic [7:0] idx_log [0:255];
  always @(posedge CLK) begin
    nw_m <= New_Word;
    if (New_Word && !nw_m) begin
      idx_log[nw_rises[7:0]] <= Tbl_Idx;
      nw_rises <= nw_rises + 1;
    end
    if (New_Word) cur_len <= cur_len + 1;
    else begin
      if (nw_m && cur_len != PL) bad_len <= bad_len + 1;
      cur_len <= 0;
    end
  end

  task automatic do_reset;
    RST_n = 1'b0;
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);
  endtask

  task automatic pulse_start;
    @(negedge CLK); Start = 1'b1;
    @(negedge CLK); Start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!Busy) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
  endtask

  task automatic wait_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (Host_Ack) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    int acks = 0, base;
    RST_n = 1'b0;
    @(negedge CLK);
    checks++; if ({New_Word, Busy, Init_Done, Error, Host_Ack, RW} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000000", {New_Word, Busy, Init_Done, Error, Host_Ack, RW}); end
    checks++; if (Err_Idx !== 8'h00) begin failures++; $display("FAIL reset_err_idx got=%h exp=00", Err_Idx); end
    checks++; if (Tbl_Idx !== 8'h00) begin failures++; $display("FAIL reset_tbl_idx got=%h exp=00", Tbl_Idx); end
    checks++; if (Host_Q !== 8'h00) begin failures++; $display("FAIL reset_host_q got=%h exp=00", Host_Q); end
    checks++; if ({Addr, Data} !== 21'h0) begin failures++; $display("FAIL reset_addr_data got=%h exp=0", {Addr, Data}); end
    RST_n = 1'b1;
    base = nw_rises;
    Host_Req = 1'b1; Host_RW = 1'b1; Host_Addr = 13'h0055;
    for (int i = 0; i < 20; i++) begin @(negedge CLK); if (Host_Ack) acks++; end
    Host_Req = 1'b0;
    checks++; if (acks != 0 || nw_rises != base) begin failures++; $display("FAIL idle_host_ignored acks=%0d words=%0d exp=0,0", acks, nw_rises - base); end
  endtask

  task automatic test_walk;
    int base, bl;
    bit ok;
    logic [7:0] k;
    do_reset;
    model_q = 8'h5A;
    base = nw_rises; bl = bad_len;
    pulse_start;
    wait_idle(1000, ok);
    repeat (2) @(negedge CLK);
    checks++; if (!ok) begin failures++; $display("FAIL walk_done got=busy exp=idle"); end
    checks++; if (nw_rises - base != 4) begin failures++; $display("FAIL walk_pulses got=%0d exp=4", nw_rises - base); end
    checks++; if (bad_len != bl) begin failures++; $display("FAIL walk_pulse_len bad=%0d exp=0", bad_len - bl); end
    for (int i = 0; i < 4; i++) begin
      k = 8'(base + i);
      checks++; if (idx_log[k] !== 8'(i)) begin failures++; $display("FAIL walk_idx%0d got=%0d exp=%0d", i, idx_log[k], i); end
    end
    checks++; if ({Init_Done, Error, Busy} !== 3'b100) begin failures++; $display("FAIL walk_status got=%b exp=100", {Init_Done, Error, Busy}); end
  endtask

  task automatic test_verify_err;
    bit ok;
    do_reset;
    model_q = 8'h5B;
    pulse_start;
    wait_idle(1000, ok);
    checks++; if (!ok || Error !== 1'b1) begin failures++; $display("FAIL verr_error got=%b exp=1", Error); end
    checks++; if (Err_Idx !== 8'h03) begin failures++; $display("FAIL verr_idx got=%h exp=03", Err_Idx); end
    checks++; if (Init_Done !== 1'b0) begin failures++; $display("FAIL verr_init got=%b exp=0", Init_Done); end
    model_q = 8'h5A;
    pulse_start;
    checks++; if (Error !== 1'b0 || Busy !== 1'b1) begin failures++; $display("FAIL verr_restart err=%b busy=%b exp=0,1", Error, Busy); end
    wait_idle(1000, ok);
    checks++; if (!ok || {Init_Done, Error} !== 2'b10) begin failures++; $display("FAIL verr_rerun got=%b exp=10", {Init_Done, Error}); end
  endtask

  task automatic test_timeout;
    int t_fall = -1, t_err = -1;
    logic nw_prev = 1'b0;
    do_reset;
    hang_en = 1'b1; hang_idx = 8'd1; model_q = 8'h5A;
    @(negedge CLK); Start = 1'b1;
    @(negedge CLK); Start = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge CLK);
      if (nw_prev && !New_Word) t_fall = k;
      nw_prev = New_Word;
      if (Error) begin t_err = k; break; end
    end
    checks++; if (t_err < 0 || t_fall < 0 || (t_err - t_fall) < TO || (t_err - t_fall) > TO + 2) begin failures++; $display("FAIL timeout_delay got=%0d exp=%0d", t_err - t_fall, TO + 1); end
    checks++; if (Err_Idx !== 8'h01) begin failures++; $display("FAIL timeout_idx got=%h exp=01", Err_Idx); end
    repeat (3) @(negedge CLK);
    checks++; if ({Init_Done, Busy, Error} !== 3'b001) begin failures++; $display("FAIL timeout_state got=%b exp=001", {Init_Done, Busy, Error}); end
    hang_en = 1'b0;
  endtask

  task automatic test_host;
    bit ok;
    int acks = 0;
    do_reset;
    model_q = 8'h5A;
    pulse_start;
    wait_idle(1000, ok);
    model_q = 8'hC3;
    Host_RW = 1'b1; Host_Addr = 13'h0014; Host_Data = 8'h00; Host_Req = 1'b1;
    wait_ack(500, ok);
    Host_Req = 1'b0;
    checks++; if (!ok || Host_Q !== 8'hC3) begin failures++; $display("FAIL host_read_q got=%h exp=c3", Host_Q); end
    checks++; if (Addr !== 13'h0014 || RW !== 1'b1) begin failures++; $display("FAIL host_read_addr got=%h/%b exp=0014/1", Addr, RW); end
    for (int i = 0; i < 10; i++) begin @(negedge CLK); if (Host_Ack) acks++; end
    checks++; if (acks != 0) begin failures++; $display("FAIL host_ack_single got=%0d exp=0", acks); end
    model_q = 8'h77;
    Host_RW = 1'b0; Host_Addr = 13'h0100; Host_Data = 8'h99; Host_Req = 1'b1;
    wait_ack(500, ok);
    Host_Req = 1'b0;
    checks++; if (!ok || Host_Q !== 8'hC3) begin failures++; $display("FAIL host_write_q got=%h exp=c3", Host_Q); end
    checks++; if ({Addr, Data, RW} !== {13'h0100, 8'h99, 1'b0}) begin failures++; $display("FAIL host_write_bus got=%h/%h/%b exp=0100/99/0", Addr, Data, RW); end
  endtask

  task automatic test_host_during_walk;
    bit ok, done = 1'b0;
    int early = 0, base;
    do_reset;
    model_q = 8'h5A;
    Host_RW = 1'b1; Host_Addr = 13'h0020; Host_Req = 1'b1;
    pulse_start;
    for (int i = 0; i < 1000; i++) begin
      if (Host_Ack) early++;
      if (Init_Done) begin done = 1'b1; break; end
      @(negedge CLK);
    end
    checks++; if (!done || early != 0) begin failures++; $display("FAIL walk_host_blocked done=%b acks=%0d exp=1,0", done, early); end
    wait_ack(500, ok);
    Host_Req = 1'b0;
    checks++; if (!ok || Host_Q !== 8'h5A) begin failures++; $display("FAIL walk_host_served got=%h exp=5a", Host_Q); end
    base = nw_rises;
    repeat (3) pulse_start;
    repeat (20) @(negedge CLK);
    checks++; if (nw_rises != base || Busy !== 1'b0 || Init_Done !== 1'b1) begin failures++; $display("FAIL done_start_ignored words=%0d busy=%b init=%b exp=0,0,1", nw_rises - base, Busy, Init_Done); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int base;
    logic [7:0] k;
    do_reset;
    hang_en = 1'b1; hang_idx = 8'd2; model_q = 8'h5A;
    base = nw_rises;
    pulse_start;
    for (int i = 0; i < 500 && (nw_rises - base) < 3; i++) @(negedge CLK);
    for (int i = 0; i < 50 && New_Word; i++) @(negedge CLK);
    repeat (10) @(negedge CLK);
    checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL rmid_pre_busy got=%b exp=1", Busy); end
    #2 RST_n = 1'b0;
    #1;
    checks++; if ({New_Word, Busy, Init_Done} !== 3'b000 || Tbl_Idx !== 8'h00) begin failures++; $display("FAIL rmid_async got=%b idx=%h exp=000/00", {New_Word, Busy, Init_Done}, Tbl_Idx); end
    @(negedge CLK);
    RST_n = 1'b1; hang_en = 1'b0;
    base = nw_rises;
    pulse_start;
    wait_idle(1000, ok);
    repeat (2) @(negedge CLK);
    k = 8'(base);
    checks++; if (idx_log[k] !== 8'h00 || nw_rises - base != 4) begin failures++; $display("FAIL rmid_restart first=%0d words=%0d exp=0,4", idx_log[k], nw_rises - base); end
    checks++; if (!ok || {Init_Done, Error} !== 2'b10) begin failures++; $display("FAIL rmid_done got=%b exp=10", {Init_Done, Error}); end
  endtask

  initial begin
    test_reset;
    test_walk;
    test_verify_err;
    test_timeout;
    test_host;
    test_host_during_walk;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
